// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm_pkg
// Description : Shared constants and state encoding for the cache block-fill
//               controller (block geometry, counter widths, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package cache_fill_fsm_pkg;

    // Block geometry: 8 words of 16 bits = 16 bytes per block.
    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_W          = 16;
    localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int OFFSET_BITS     = WORD_IDX_W + 1;

    // Counters need one extra bit so they can saturate at WORDS_PER_BLOCK.
    localparam int CNT_W           = WORD_IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage : cache_fill_fsm_pkg
`default_nettype wire

// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm_if
// Description : Bundle of the cache-side, memory-side and array-write signals
//               of the fill controller.
//               master : the fill controller
//               slave  : cache/memory environment
//   miss_detected, miss_address       : miss request from the cache
//   fsm_busy                          : fill in progress
//   memory_address, memory_enable     : read request to memory
//   memory_data, memory_data_valid    : in-order read return from memory
//   fill_word_index, fill_data,
//   write_data_array, write_tag_array : writes into the cache arrays
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  fsm_busy;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  memory_enable;
    logic [WORD_W-1:0]     memory_data;
    logic                  memory_data_valid;
    logic [WORD_IDX_W-1:0] fill_word_index;
    logic [WORD_W-1:0]     fill_data;
    logic                  write_data_array;
    logic                  write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, memory_address, memory_enable, fill_word_index,
               fill_data, write_data_array, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, memory_address, memory_enable, fill_word_index,
               fill_data, write_data_array, write_tag_array
    );

endinterface : cache_fill_fsm_if
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm_fill_counter
// Description : Saturating up-counter with enable and synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : count enable
//   cnt_o    : current count, holds at MAX once reached
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm_fill_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != WIDTH'(MAX))) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : cache_fill_fsm_fill_counter
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss fill controller. Fetches one 8-word block from
//               memory with decoupled issue and receive counters so it works
//               with zero-latency and pipelined memories alike.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache_fill_fsm_if master modport (miss request, memory read
//              port, data/tag array write controls)
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    // Must match the ADDR_WIDTH of the connected interface instance.
    parameter int ADDR_WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cache_fill_fsm_if.master bus
);

    localparam int BASE_W = ADDR_WIDTH - OFFSET_BITS;

    fill_state_e       state_q, state_d;
    logic [BASE_W-1:0] base_q,  base_d;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  recv_cnt_q;
    logic              w_cnt_clr;
    logic              w_issue_en;
    logic              w_recv_en;

    // The block offset is discarded: every fill starts at word 0.
    logic unused_offset;
    assign unused_offset = ^bus.miss_address[OFFSET_BITS-1:0];

    cache_fill_fsm_fill_counter #(
        .WIDTH (CNT_W),
        .MAX   (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_cnt_clr),
        .en_i  (w_issue_en),
        .cnt_o (issue_cnt_q)
    );

    cache_fill_fsm_fill_counter #(
        .WIDTH (CNT_W),
        .MAX   (WORDS_PER_BLOCK)
    ) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_cnt_clr),
        .en_i  (w_recv_en),
        .cnt_o (recv_cnt_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        base_d               = base_q;
        w_cnt_clr            = 1'b0;
        w_issue_en           = 1'b0;
        w_recv_en            = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.memory_enable    = 1'b0;
        bus.memory_address   = '0;
        bus.fill_word_index  = '0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.fill_data        = bus.memory_data;

        // Outputs are forced quiet during reset so an in-flight fill cannot
        // write or tag a partial block in the reset cycle itself.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base_d    = bus.miss_address[ADDR_WIDTH-1:OFFSET_BITS];
                        w_cnt_clr = 1'b1;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    bus.fsm_busy         = 1'b1;
                    w_issue_en           = (issue_cnt_q < CNT_W'(WORDS_PER_BLOCK));
                    bus.memory_enable    = w_issue_en;
                    bus.memory_address   = {base_q, issue_cnt_q[WORD_IDX_W-1:0], 1'b0};
                    w_recv_en            = bus.memory_data_valid;
                    bus.write_data_array = bus.memory_data_valid;
                    bus.fill_word_index  = recv_cnt_q[WORD_IDX_W-1:0];
                    if (bus.memory_data_valid &&
                        (recv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1))) begin
                        bus.write_tag_array = 1'b1;
                        state_d             = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule : cache_fill_fsm
`default_nettype wire

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller between the cache arrays and main memory.
- On a cache miss it fetches one 16-byte block (8 × 16-bit words) from memory, word by word.
- Each returned word is steered into the cache data array; the tag array is written on the last word.
- Address issue and data return are decoupled, so the block works with both the zero-latency memory and a pipelined multi-cycle memory.

Parameters:
ADDR_WIDTH, 16, byte-address width; must match the memory.
WORDS_PER_BLOCK, 8, words per cache block; power of two; 16-bit words.
OFFSET_BITS, 4, log2(bytes per block) = log2(WORDS_PER_BLOCK) + 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
miss_detected  input  1  cache miss this cycle; sampled only in IDLE.
miss_address  input  ADDR_WIDTH  byte address of the missing access.
fsm_busy  output  1  high while a fill is in progress.
memory_address  output  ADDR_WIDTH  word-aligned read address to memory.
memory_enable  output  1  read request to memory, with wr tied low externally.
memory_data  input  16  read data from memory.
memory_data_valid  input  1  memory_data carries the next word in request order.
fill_word_index  output  log2(WORDS_PER_BLOCK)  word slot in the block for the current write.
fill_data  output  16  data to the cache data array; equals memory_data.
write_data_array  output  1  write enable to the cache data array.
write_tag_array  output  1  single-cycle pulse that writes the tag and sets the valid bit.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: state = IDLE; issue_cnt = 0; recv_cnt = 0; base address register = 0.
  - All outputs are 0 during reset and in the first cycle after reset (fill_data follows memory_data but is qualified by write_data_array = 0).
- States: IDLE, FILL.
- IDLE:
  - Outputs fsm_busy, memory_enable, write_data_array and write_tag_array are 0.
  - If miss_detected = 1: latch base = miss_address[ADDR_WIDTH-1:OFFSET_BITS], clear both counters, go to FILL next cycle.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy = 1.
  - Issue side: memory_enable = (issue_cnt < WORDS_PER_BLOCK). memory_address = {base, issue_cnt[2:0], 1'b0}. issue_cnt increments each cycle while memory_enable = 1 and saturates at WORDS_PER_BLOCK.
  - Receive side: write_data_array = memory_data_valid. fill_word_index = recv_cnt. recv_cnt increments on each valid.
  - Completion: when memory_data_valid = 1 and recv_cnt = WORDS_PER_BLOCK-1, write_tag_array = 1 in that same cycle, and the state returns to IDLE next cycle.
- Latency: with valid asserted in the same cycle as enable (zero-latency memory), the fill takes exactly 8 FILL cycles. Total busy cycles = 8 + memory latency.
- miss_detected asserted during FILL is ignored. A new miss is accepted only in IDLE, i.e. the earliest is the cycle after write_tag_array.
- memory_address is always word-aligned (bit 0 = 0). The offset bits of miss_address are discarded, so the fill starts at word 0 regardless of which word missed.
- Wrap-around: base 0xFFF with issue_cnt 7 gives 0xFFFE. No carry into the tag bits, no overflow.
- Valid beyond 8 words in one FILL cannot occur, because the FSM leaves FILL on the 8th.
- Reset asserted mid-fill: next cycle is IDLE with counters cleared. Any partially written block is not tagged (write_tag_array never pulses). Memory responses arriving after reset are ignored.
- Simultaneous rst and miss_detected: reset wins.

Decomposition:
- Shared package: state encoding (IDLE = 1'b0, FILL = 1'b1), WORDS_PER_BLOCK, OFFSET_BITS, and the word-index width.
- One natural sub-module: fill_counter. It is a saturating up-counter with enable and synchronous clear, instantiated twice (issue_cnt and recv_cnt).
- The rest is flat FSM plus address concatenation.

Test Plan:
1. Miss at 0x1236 with zero-latency memory (valid = enable):
   - Addresses 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
   - fill_word_index 0..7, with write_data_array high on all 8.
   - write_tag_array pulses on the 8th cycle; fsm_busy low on cycle 9.
2. Miss at 0x0040 with valid delayed 3 cycles:
   - memory_enable is high for exactly 8 cycles.
   - write_data_array goes high in cycles 4–11, with fill_data matching the preloaded words.
   - fsm_busy is high for 11 cycles.
3. miss_detected = 1 on every cycle of a fill at 0x2000: no restart. The second miss at 0x3000 is taken only in the cycle after write_tag_array, and its first address is 0x3000.
4. rst asserted after the 4th word of a fill at 0x0100:
   - Next cycle: IDLE, all outputs 0, no write_tag_array.
   - A stray valid afterwards produces no write_data_array.
5. Miss at 0xFFFF: addresses 0xFFF0 … 0xFFFE with bit 0 clear; tag write pulses normally.
6. memory_data_valid toggled while idle, and rst held together with miss_detected: write_data_array, write_tag_array and fsm_busy all stay 0.
